// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: datapath/memory bundle between the multi-cycle controller and
// the rest of the CPU.
//   master (controller): drives memory strobes, datapath selects, ALU
//                        controls, illegal pulse and retired count; receives
//                        opcode/funct, aluzero and mem_ready.
//   slave  (datapath/memory side): the mirror image.
interface mc_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             aluzero;
   logic             mem_ready;
   logic             mem_req;
   logic             mem_we;
   logic             iord;
   logic             irwrite;
   logic             mdrwrite;
   logic             pcwrite;
   logic [1:0]       pcsrc;
   logic             alusrc;
   logic [2:0]       aluctrl;
   logic             extzero;
   logic             regwrite;
   logic             regdst;
   logic             memtoreg;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, funct, aluzero, mem_ready,
      output mem_req, mem_we, iord, irwrite, mdrwrite, pcwrite, pcsrc,
             alusrc, aluctrl, extzero, regwrite, regdst, memtoreg,
             illegal, retired
   );

   modport slave (
      output opcode, funct, aluzero, mem_ready,
      input  mem_req, mem_we, iord, irwrite, mdrwrite, pcwrite, pcsrc,
             alusrc, aluctrl, extzero, regwrite, regdst, memtoreg,
             illegal, retired
   );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB).
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mc_ctrl_if.master: opcode/funct/aluzero/mem_ready in; memory
//          handshake, datapath selects, ALU controls, illegal pulse and
//          retired-instruction counter out.
// Outputs are combinational from state and the latched instruction; branch
// pcwrite additionally looks at aluzero.
module mc_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   mc_ctrl_if.master     bus
);
   localparam logic [2:0] ALU_AND = 3'd0, ALU_OR  = 3'd1, ALU_ADD = 3'd2,
                          ALU_XOR = 3'd4, ALU_SUB = 3'd6, ALU_SLT = 3'd7;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
   typedef enum logic [2:0] {C_R, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_ILL} cls_t;

   function automatic cls_t cls_of(input logic [5:0] op, input logic [5:0] fn);
      cls_t c;
      case (op)
         6'h00: c = (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                6'h26, 6'h2A}) ? C_R : C_ILL;
         6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: c = C_IALU;
         6'h23: c = C_LW;
         6'h2B: c = C_SW;
         6'h04: c = C_BEQ;
         6'h05: c = C_BNE;
         6'h02: c = C_J;
         default: c = C_ILL;
      endcase
      return c;
   endfunction

   // {extzero, aluctrl}; memory ops fall to ADD, branches to SUB
   function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
      logic [3:0] r;
      r = {1'b0, ALU_ADD};
      case (op)
         6'h00: case (fn)
            6'h22, 6'h23: r = {1'b0, ALU_SUB};
            6'h24:        r = {1'b0, ALU_AND};
            6'h25:        r = {1'b0, ALU_OR};
            6'h26:        r = {1'b0, ALU_XOR};
            6'h2A:        r = {1'b0, ALU_SLT};
            default:      r = {1'b0, ALU_ADD};
         endcase
         6'h0A:        r = {1'b0, ALU_SLT};
         6'h0C:        r = {1'b1, ALU_AND};
         6'h0D:        r = {1'b1, ALU_OR};
         6'h0E:        r = {1'b1, ALU_XOR};
         6'h04, 6'h05: r = {1'b0, ALU_SUB};
         default:      r = {1'b0, ALU_ADD};
      endcase
      return r;
   endfunction

   state_t           state, nxt;
   logic [5:0]       op_q, fn_q;
   logic [CNT_W-1:0] cnt;
   cls_t             cls_now, cls_q;
   logic [3:0]       alu_q;
   logic             retire;

   logic       mem_req, mem_we, iord, irwrite, mdrwrite, pcwrite;
   logic [1:0] pcsrc;
   logic       alusrc, extzero, regwrite, regdst, memtoreg, illegal;
   logic [2:0] aluctrl;

   // DECODE decides from the live IR; later states use the latched copy
   assign cls_now = cls_of(bus.opcode, bus.funct);
   assign cls_q   = cls_of(op_q, fn_q);
   assign alu_q   = alu_of(op_q, fn_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         op_q  <= '0;
         fn_q  <= '0;
         cnt   <= '0;
      end else begin
         state <= nxt;
         if (state == DECODE) begin
            op_q <= bus.opcode;
            fn_q <= bus.funct;
         end
         if (retire) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      nxt      = state;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      mdrwrite = 1'b0;
      pcwrite  = 1'b0;
      pcsrc    = 2'd0;
      alusrc   = 1'b0;
      aluctrl  = ALU_ADD;
      extzero  = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      illegal  = 1'b0;
      retire   = 1'b0;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               nxt     = DECODE;
            end
         end
         DECODE: begin
            case (cls_now)
               C_J: begin
                  pcwrite = 1'b1;
                  pcsrc   = 2'd2;
                  retire  = 1'b1;
                  nxt     = FETCH;
               end
               C_ILL: begin
                  illegal = 1'b1;
                  nxt     = FETCH;
               end
               default: nxt = EXEC;
            endcase
         end
         EXEC: begin
            aluctrl = alu_q[2:0];
            extzero = alu_q[3];
            alusrc  = (cls_q inside {C_IALU, C_LW, C_SW});
            case (cls_q)
               C_R, C_IALU: nxt = WB;
               C_LW, C_SW:  nxt = MEM;
               C_BEQ, C_BNE: begin
                  if ((cls_q == C_BEQ && bus.aluzero) ||
                      (cls_q == C_BNE && !bus.aluzero)) begin
                     pcwrite = 1'b1;
                     pcsrc   = 2'd1;
                  end
                  retire = 1'b1;
                  nxt    = FETCH;
               end
               default: nxt = FETCH;   // unreachable: DECODE filters J/illegal
            endcase
         end
         MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = (cls_q == C_SW);
            if (bus.mem_ready) begin
               if (cls_q == C_SW) begin
                  retire = 1'b1;
                  nxt    = FETCH;
               end else begin
                  mdrwrite = 1'b1;
                  nxt      = WB;
               end
            end
         end
         WB: begin
            regwrite = 1'b1;
            regdst   = (cls_q == C_R);
            memtoreg = (cls_q == C_LW);
            retire   = 1'b1;
            nxt      = FETCH;
         end
         default: nxt = FETCH;
      endcase
      // State is already FETCH during reset; force everything quiet so an
      // in-flight request is withdrawn in the same cycle rst rises.
      if (rst) begin
         mem_req  = 1'b0;
         mem_we   = 1'b0;
         iord     = 1'b0;
         irwrite  = 1'b0;
         mdrwrite = 1'b0;
         pcwrite  = 1'b0;
         pcsrc    = 2'd0;
         alusrc   = 1'b0;
         aluctrl  = 3'd0;
         extzero  = 1'b0;
         regwrite = 1'b0;
         regdst   = 1'b0;
         memtoreg = 1'b0;
         illegal  = 1'b0;
         retire   = 1'b0;
      end
   end

   assign bus.mem_req  = mem_req;
   assign bus.mem_we   = mem_we;
   assign bus.iord     = iord;
   assign bus.irwrite  = irwrite;
   assign bus.mdrwrite = mdrwrite;
   assign bus.pcwrite  = pcwrite;
   assign bus.pcsrc    = pcsrc;
   assign bus.alusrc   = alusrc;
   assign bus.aluctrl  = aluctrl;
   assign bus.extzero  = extzero;
   assign bus.regwrite = regwrite;
   assign bus.regdst   = regdst;
   assign bus.memtoreg = memtoreg;
   assign bus.illegal  = illegal;
   assign bus.retired  = cnt;
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the CPU datapath; the issuing side of the ALU interface.
- Decodes the latched instruction opcode/funct and drives alusrc and aluctrl (3-bit op codes) to the ALU.
- Consumes aluzero to resolve branches.
- Sequences fetch/decode/execute/memory/writeback with a req/ready memory handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
opcode  input  6  IR[31:26], stable from DECODE until the next FETCH
funct  input  6  IR[5:0]
aluzero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request
mem_we  output  1  write enable, valid with mem_req
iord  output  1  0: address=PC, 1: address=ALU result register
irwrite  output  1  load IR from read data
mdrwrite  output  1  load MDR from read data
pcwrite  output  1  update PC this cycle
pcsrc  output  2  0: PC+4, 1: branch target, 2: jump target
alusrc  output  1  0: ALU B = register, 1: ALU B = sign/zero-extended immediate
aluctrl  output  3  0 AND, 1 OR, 2 ADD, 4 XOR, 6 SUB, 7 SLT
extzero  output  1  1: zero-extend immediate (andi/ori/xori)
regwrite  output  1  register file write
regdst  output  1  1: write rd, 0: write rt
memtoreg  output  1  1: write-back from MDR, 0: from ALU result register
illegal  output  1  one-cycle pulse on undecodable instruction
retired  output  CNT_W  count of completed instructions, wraps

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB. Outputs are combinational from state and latched op/funct, except branch pcwrite (also depends on aluzero).
- Reset (async): state=FETCH, retired=0, latched op/funct=0.
  - All strobes are 0 while rst=1. Strobes: mem_req, mem_we, irwrite, mdrwrite, pcwrite, regwrite, illegal.
  - Select outputs are 0 while rst=1.
  - mem_req first rises the cycle after rst deasserts.
- FETCH:
  - mem_req=1, iord=0, mem_we=0.
  - Hold until mem_ready.
  - On the mem_ready cycle: irwrite=1, pcwrite=1, pcsrc=0, then go to DECODE.
- DECODE:
  - Latch opcode/funct.
  - Legal R-type (op 0x00): funct 0x20/0x21 -> ADD, 0x22/0x23 -> SUB, 0x24 -> AND, 0x25 -> OR, 0x26 -> XOR, 0x2A -> SLT.
  - Legal I-type: 0x08/0x09 -> ADD, 0x0A -> SLT, 0x0C -> AND ext0, 0x0D -> OR ext0, 0x0E -> XOR ext0, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne.
  - j (0x02): pcwrite=1, pcsrc=2, retired++, go to FETCH.
  - Illegal: illegal=1 for one cycle, go to FETCH; retired unchanged.
  - All other legal instructions go to EXEC.
- EXEC:
  - R-type: alusrc=0, decoded aluctrl, go to WB.
  - I-type ALU: alusrc=1, go to WB.
  - lw/sw: alusrc=1, aluctrl=ADD, extzero=0, go to MEM.
  - beq/bne: alusrc=0, aluctrl=SUB.
    - pcwrite=1, pcsrc=1 iff (beq & aluzero) | (bne & ~aluzero).
    - retired++, go to FETCH.
- MEM:
  - mem_req=1, iord=1, mem_we=(sw). Hold until mem_ready.
  - sw: retired++, go to FETCH.
  - lw: mdrwrite=1, go to WB.
- WB:
  - regwrite=1 for exactly one cycle, retired++, go to FETCH.
  - regdst=1 for R-type, else 0.
  - memtoreg=1 for lw, else 0.
- Don't-care defaults outside listed states: alusrc=0, aluctrl=ADD, pcsrc=0, extzero=0.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-transaction drops mem_req immediately; memory must discard the request.
- retired wraps from 2^CNT_W-1 to 0.
- Cycle counts (zero-wait memory):
  - R/I ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
  - j: 2 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- add (op 0, funct 0x20), mem_ready always 1 -> FETCH->DECODE->EXEC(alusrc=0, aluctrl=2)->WB(regwrite=1, regdst=1, memtoreg=0); retired 0->1 after 4 cycles.
- lw (0x23), mem_ready low 2 cycles in MEM -> mem_req=1, iord=1, mem_we=0 held 3 cycles, mdrwrite pulse on ready; WB memtoreg=1, regdst=0; 7 cycles total.
- beq with aluzero=1 -> EXEC pcwrite=1, pcsrc=1, aluctrl=6. bne with aluzero=1 -> pcwrite=0. Both: retired+1, next state FETCH.
- ori (0x0D), then slti (0x0A) -> EXEC: ori alusrc=1, aluctrl=1, extzero=1; slti aluctrl=7, extzero=0.
- opcode 0x3F -> illegal pulse 1 cycle in DECODE, no regwrite/pcwrite beyond fetch, retired unchanged.
- rst asserted during MEM of sw with mem_req=1 -> mem_req, mem_we drop same cycle, retired=0; after release FETCH issues mem_req with iord=0. Set CNT_W=2: after 4 retirements retired wraps to 0.
